// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter in front of a 1024x32 single-port on-chip RAM.
// Each access is serialised through IDLE -> ISSUE (-> DATA for reads) with no pipelining.
module onchip_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t state, next_state;
  logic   last_grant, next_grant;
  logic   capture;
  logic   m0_req, m1_req;

  logic [ADDR_W-1:0] cap_address;
  logic [BE_W-1:0]   cap_byteenable;
  logic [DATA_W-1:0] cap_writedata;
  logic              cap_write;
  logic              grant_done;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  always_comb begin
    next_state = state;
    next_grant = last_grant;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          capture    = 1'b1;
          next_grant = ~last_grant;
        end else if (m0_req) begin
          capture    = 1'b1;
          next_grant = 1'b0;
        end else if (m1_req) begin
          capture    = 1'b1;
          next_grant = 1'b1;
        end
        if (capture) next_state = ISSUE;
      end
      ISSUE:   next_state = cap_write ? IDLE : DATA;
      DATA:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A simultaneous read+write carries write=1 into cap_write, so it is treated as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      cap_address    <= '0;
      cap_byteenable <= '0;
      cap_writedata  <= '0;
      cap_write      <= 1'b0;
    end else begin
      state      <= next_state;
      last_grant <= next_grant;
      if (capture) begin
        cap_address    <= next_grant ? m1_address    : m0_address;
        cap_byteenable <= next_grant ? m1_byteenable : m0_byteenable;
        cap_writedata  <= next_grant ? m1_writedata  : m0_writedata;
        cap_write      <= next_grant ? m1_write      : m0_write;
      end
    end
  end

  assign ram_address    = cap_address;
  assign ram_byteenable = cap_byteenable;
  assign ram_writedata  = cap_writedata;
  assign ram_chipselect = (state == ISSUE);
  assign ram_write      = (state == ISSUE) && cap_write;
  assign ram_clken      = 1'b1;
  assign busy           = (state != IDLE);

  // Release decoded purely from registered state so waitrequest never depends on req.
  assign grant_done     = ((state == ISSUE) && cap_write) || (state == DATA);
  assign m0_waitrequest = ~(grant_done && !last_grant);
  assign m1_waitrequest = ~(grant_done &&  last_grant);

  assign m0_readdata = ram_readdata;
  assign m1_readdata = ram_readdata;

endmodule
